// File: rtl/sdm2_modulator.sv
`default_nettype none
// ============================================================================
// sdm2_modulator : second-order 1-bit sigma-delta modulator with integrator
//                  overload detection, timed recovery and overload counting.
// Rev 1.0
// ============================================================================
module sdm2_modulator #(
  parameter int DW          = 24,
  parameter int IW          = 30,
  parameter int OVF_TH      = 67108864,
  parameter int HOLD_CYCLES = 16
) (
  input  logic          clock_up,
  input  logic          rst,
  input  logic [DW-1:0] Data_in,
  input  logic          in_en,
  output logic          Data_out,
  output logic          out_valid,
  output logic          recover,
  output logic [7:0]    ovf_cnt
);

  localparam int SW = IW + 2;
  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam logic signed [SW-1:0] FS      = {{(SW-DW){1'b0}}, 1'b1, {(DW-1){1'b0}}};
  localparam logic signed [SW-1:0] SAT_MAX = {{(SW-IW+1){1'b0}}, {(IW-1){1'b1}}};
  localparam logic signed [SW-1:0] SAT_MIN = {{(SW-IW+1){1'b1}}, {(IW-1){1'b0}}};
  localparam logic signed [SW-1:0] TH_POS  = SW'(OVF_TH);
  localparam logic signed [SW-1:0] TH_NEG  = -TH_POS;
  localparam logic [HW-1:0]        HOLD_LD = HW'(HOLD_CYCLES);

  typedef enum logic [0:0] {
    ST_RUN     = 1'b0,
    ST_RECOVER = 1'b1
  } state_t;

  state_t               state_q, state_d;
  logic signed [IW-1:0] x1_q, x1_d, x2_q, x2_d;
  logic [HW-1:0]        hold_cnt_q, hold_cnt_d;
  logic                 dout_q, dout_d;
  logic                 valid_q, valid_d;
  logic                 recover_q, recover_d;
  logic [7:0]           ovf_cnt_q, ovf_cnt_d;

  logic                 y;
  logic                 ovf;
  logic signed [SW-1:0] u, fb, x1_ext, x2_ext, x1_sum, x2_sum;

  function automatic logic signed [IW-1:0] sat(input logic signed [SW-1:0] v);
    if (v > SAT_MAX)      return SAT_MAX[IW-1:0];
    else if (v < SAT_MIN) return SAT_MIN[IW-1:0];
    else                  return v[IW-1:0];
  endfunction

  // Delaying integrators: x2 accumulates the OLD x1, giving NTF = (1-z^-1)^2.
  assign y      = ~x2_q[IW-1];
  assign fb     = y ? FS : -FS;
  assign u      = {{(SW-DW){Data_in[DW-1]}}, Data_in};
  assign x1_ext = {{(SW-IW){x1_q[IW-1]}}, x1_q};
  assign x2_ext = {{(SW-IW){x2_q[IW-1]}}, x2_q};
  assign x1_sum = x1_ext + u - fb;
  assign x2_sum = x2_ext + x1_ext - (fb <<< 1);
  assign ovf    = (x2_sum > TH_POS) || (x2_sum < TH_NEG);

  always_comb begin
    state_d    = state_q;
    x1_d       = x1_q;
    x2_d       = x2_q;
    hold_cnt_d = hold_cnt_q;
    dout_d     = dout_q;
    valid_d    = 1'b0;
    ovf_cnt_d  = ovf_cnt_q;
    if (in_en) begin
      valid_d = 1'b1;
      case (state_q)
        ST_RUN: begin
          dout_d = y;
          if (ovf) begin
            x1_d       = '0;
            x2_d       = '0;
            state_d    = ST_RECOVER;
            hold_cnt_d = HOLD_LD;
            if (ovf_cnt_q != 8'hFF) ovf_cnt_d = ovf_cnt_q + 8'd1;
          end else begin
            x1_d = sat(x1_sum);
            x2_d = sat(x2_sum);
          end
        end
        ST_RECOVER: begin
          // Idle tone while the integrators stay cleared.
          dout_d     = ~dout_q;
          hold_cnt_d = hold_cnt_q - HW'(1);
          if (hold_cnt_q == HW'(1)) state_d = ST_RUN;
        end
        default: state_d = ST_RUN;
      endcase
    end
    recover_d = (state_d == ST_RECOVER);
  end

  always_ff @(posedge clock_up) begin
    if (rst) begin
      state_q    <= ST_RUN;
      x1_q       <= '0;
      x2_q       <= '0;
      hold_cnt_q <= '0;
      dout_q     <= 1'b0;
      valid_q    <= 1'b0;
      recover_q  <= 1'b0;
      ovf_cnt_q  <= 8'd0;
    end else begin
      state_q    <= state_d;
      x1_q       <= x1_d;
      x2_q       <= x2_d;
      hold_cnt_q <= hold_cnt_d;
      dout_q     <= dout_d;
      valid_q    <= valid_d;
      recover_q  <= recover_d;
      ovf_cnt_q  <= ovf_cnt_d;
    end
  end

  assign Data_out  = dout_q;
  assign out_valid = valid_q;
  assign recover   = recover_q;
  assign ovf_cnt   = ovf_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_sdm2_modulator.sv
`default_nettype none
// ============================================================================
// tb_sdm2_modulator : scoreboard bench; instance a uses default parameters,
//                     instance b uses a low overload threshold and short hold.
// Rev 1.0
// ============================================================================
module tb_sdm2_modulator;

  localparam longint FS     = 64'sd8388608;
  localparam longint IMAX   = 64'sd536870911;
  localparam longint IMIN   = -64'sd536870912;
  localparam logic [23:0] PFS  = 24'd8388607;
  localparam logic [23:0] HFS  = 24'd4194304;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_en_a = 1'b0, in_en_b = 1'b0;
  logic [23:0] data_a = '0, data_b = '0;
  logic        out_a, valid_a, rec_a, out_b, valid_b, rec_b;
  logic [7:0]  cnt_a, cnt_b;

  always #5 clk = ~clk;

  sdm2_modulator u_dut_a (
    .clock_up (clk), .rst (rst), .Data_in (data_a), .in_en (in_en_a),
    .Data_out (out_a), .out_valid (valid_a), .recover (rec_a), .ovf_cnt (cnt_a)
  );

  sdm2_modulator #(.OVF_TH(25165824), .HOLD_CYCLES(4)) u_dut_b (
    .clock_up (clk), .rst (rst), .Data_in (data_b), .in_en (in_en_b),
    .Data_out (out_b), .out_valid (valid_b), .recover (rec_b), .ovf_cnt (cnt_b)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model, one slot per instance
  longint m_th[2] = '{64'sd67108864, 64'sd25165824};
  longint m_hc[2] = '{64'sd16, 64'sd4};
  longint m_x1[2], m_x2[2], m_hold[2], m_cnt[2];
  bit     m_rec[2], m_dout[2];
  logic [9:0] q_a[$], q_b[$];

  function automatic longint sat(input longint v);
    if (v > IMAX) return IMAX;
    if (v < IMIN) return IMIN;
    return v;
  endfunction

  task automatic model_reset(input int k);
    m_x1[k] = 0; m_x2[k] = 0; m_hold[k] = 0; m_cnt[k] = 0;
    m_rec[k] = 1'b0; m_dout[k] = 1'b0;
  endtask

  task automatic model_step(input int k, input logic [23:0] din);
    longint u, fb, x1n, x2n;
    bit y;
    logic [9:0] w;
    if (!m_rec[k]) begin
      y   = (m_x2[k] >= 0);
      fb  = y ? FS : -FS;
      u   = longint'($signed(din));
      x1n = m_x1[k] + u - fb;
      x2n = m_x2[k] + m_x1[k] - 2 * fb;
      m_dout[k] = y;
      if (x2n > m_th[k] || x2n < -m_th[k]) begin
        m_x1[k] = 0; m_x2[k] = 0; m_rec[k] = 1'b1; m_hold[k] = m_hc[k];
        if (m_cnt[k] < 255) m_cnt[k]++;
      end else begin
        m_x1[k] = sat(x1n); m_x2[k] = sat(x2n);
      end
    end else begin
      m_dout[k] = !m_dout[k];
      m_hold[k]--;
      if (m_hold[k] == 0) m_rec[k] = 1'b0;
    end
    w = {m_dout[k], m_rec[k], m_cnt[k][7:0]};
    if (k == 0) q_a.push_back(w); else q_b.push_back(w);
  endtask

  // Monitors: expected out_valid, popped words, hold-between-strobes and reset values
  logic       ev_a = 1'b0, ev_b = 1'b0, rst_q = 1'b0;
  logic [9:0] last_a = '0, last_b = '0;
  int         ones_a = 0;

  always @(posedge clk) begin
    ev_a  <= in_en_a && !rst;
    ev_b  <= in_en_b && !rst;
    rst_q <= rst;
  end

  always @(negedge clk) begin
    logic [9:0] w;
    check_val("valid_a", valid_a, ev_a);
    check_val("valid_b", valid_b, ev_b);
    if (rst_q) begin
      last_a = '0;
      last_b = '0;
    end
    if (valid_a) begin
      check_val("qdepth_a", q_a.size() > 0, 1);
      if (q_a.size() > 0) begin
        w = q_a.pop_front();
        check_val("word_a", {out_a, rec_a, cnt_a}, w);
        last_a = w;
        if (out_a) ones_a++;
      end
    end else check_val("hold_a", {out_a, rec_a, cnt_a}, last_a);
    if (valid_b) begin
      check_val("qdepth_b", q_b.size() > 0, 1);
      if (q_b.size() > 0) begin
        w = q_b.pop_front();
        check_val("word_b", {out_b, rec_b, cnt_b}, w);
        last_b = w;
      end
    end else check_val("hold_b", {out_b, rec_b, cnt_b}, last_b);
  end

  task automatic drive(input int k, input logic [23:0] d, input int gap);
    if (k == 0) begin in_en_a = 1'b1; data_a = d; end
    else        begin in_en_b = 1'b1; data_b = d; end
    model_step(k, d);
    @(posedge clk); #1;
    in_en_a = 1'b0;
    in_en_b = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
  endtask

  task automatic drain;
    repeat (3) begin @(posedge clk); #1; end
    check_val("drain_a", q_a.size(), 0);
    check_val("drain_b", q_b.size(), 0);
  endtask

  task automatic do_reset;
    rst = 1'b1; in_en_a = 1'b0; in_en_b = 1'b0;
    model_reset(0); model_reset(1);
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    int base;
    model_reset(0); model_reset(1);
    // Reset held two edges with full-scale strobes present
    in_en_a = 1'b1; data_a = PFS; in_en_b = 1'b1; data_b = PFS;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0; in_en_a = 1'b0; in_en_b = 1'b0;
    @(negedge clk);
    check_val("rst_state_a", {out_a, valid_a, rec_a, cnt_a}, 0);
    @(posedge clk); #1;

    // Zero input, full rate
    base = ones_a;
    for (int i = 0; i < 1024; i++) drive(0, 24'd0, 0);
    drain();
    check_val("ones_zero_full", ones_a - base, 512);

    // DC +FS/2
    do_reset();
    base = ones_a;
    for (int i = 0; i < 4096; i++) drive(0, HFS, 0);
    drain();
    check_val("ones_dc_3072pm2", (ones_a - base >= 3070) && (ones_a - base <= 3074), 1);
    check_val("ovf_cnt_dc", cnt_a, 0);

    // Zero input, one strobe in three
    do_reset();
    base = ones_a;
    for (int i = 0; i < 768; i++) drive(0, 24'd0, 2);
    drain();
    check_val("ones_zero_gap", ones_a - base, 384);

    // Repeated overload until the counter saturates
    do_reset();
    for (int i = 0; i < 260 * 7; i++) drive(1, PFS, 0);
    drain();
    check_val("ovf_cnt_sat", cnt_b, 255);

    // Reset on the second RECOVER strobe, then a zero strobe in RUN
    do_reset();
    for (int i = 0; i < 4; i++) drive(1, PFS, 0);
    rst = 1'b1; in_en_b = 1'b1; data_b = PFS;
    model_reset(0); model_reset(1);
    @(posedge clk); #1;
    rst = 1'b0; in_en_b = 1'b0;
    @(negedge clk);
    check_val("mid_rec_rst", {out_b, rec_b, cnt_b}, 0);
    @(posedge clk); #1;
    drive(1, 24'd0, 0);
    @(negedge clk);
    check_val("post_rst_bit", {out_b, rec_b, cnt_b}, 10'h200);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
